// File: rtl/box_motion_ctrl.sv
// Button-driven box mover: debounced buttons request a move on each tick, applied only on an iVS falling edge.
// Define BOX_MOTION_WRAP_EN to wrap coordinates at the screen limits instead of clamping them.
module box_motion_ctrl #(
  parameter int TICK_DIV  = 1000000,
  parameter int STEP      = 5,
  parameter int DB_CYCLES = 50000,
  parameter int SCR_W     = 640,
  parameter int SCR_H     = 480,
  parameter int BOX_W     = 160,
  parameter int BOX_H     = 160,
  parameter int X_INIT    = 120,
  parameter int Y_INIT    = 120
) (
  input  logic       iVGA_CLK,
  input  logic       iRST_n,
  input  logic       in1,
  input  logic       in2,
  input  logic       in3,
  input  logic       in4,
  input  logic       iVS,
  output logic [9:0] oBOX_X,
  output logic [9:0] oBOX_Y,
  output logic       oMOVING
);

  localparam int TW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CYCLES - 1);

  localparam logic signed [11:0] STEP_S = 12'(STEP);
  localparam logic signed [11:0] X_MAX  = 12'(SCR_W - BOX_W);
  localparam logic signed [11:0] Y_MAX  = 12'(SCR_H - BOX_H);
  localparam logic [9:0]         X_MAX10 = 10'(SCR_W - BOX_W);
  localparam logic [9:0]         Y_MAX10 = 10'(SCR_H - BOX_H);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    APPLY = 2'd2
  } state_t;

  // Button bit order: [0] right, [1] left, [2] down, [3] up; all active-low.
  logic [3:0]     btn_raw;
  logic [3:0]     sync1;
  logic [3:0]     sync2;
  logic [3:0]     db_lvl;
  logic [DBW-1:0] db_cnt [4];
  logic [3:0]     req;

  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic          vs_q;
  logic          vs_fall;

  state_t state;
  state_t state_nxt;
  logic   latch_req;
  logic   do_apply;

  logic signed [11:0] dx;
  logic signed [11:0] dy;
  logic signed [11:0] x_sum;
  logic signed [11:0] y_sum;
  logic [9:0]         x_new;
  logic [9:0]         y_new;

  assign btn_raw = {in4, in3, in2, in1};

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // Level flips only after DB_CYCLES consecutive cycles disagreeing with it.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      db_lvl <= '1;
      for (int i = 0; i < 4; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == db_lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_lvl[i] <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      tick_cnt <= '0;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      vs_q <= 1'b1;
    end else begin
      vs_q <= iVS;
    end
  end

  assign vs_fall = vs_q & ~iVS;

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Ticks outside IDLE are simply ignored, so at most one request is ever pending.
  always_comb begin
    state_nxt = state;
    latch_req = 1'b0;
    do_apply  = 1'b0;
    case (state)
      IDLE: begin
        if (tick && (db_lvl != 4'hF)) begin
          latch_req = 1'b1;
          state_nxt = ARMED;
        end
      end
      ARMED: begin
        if (vs_fall) begin
          state_nxt = APPLY;
        end
      end
      APPLY: begin
        do_apply  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      req <= '1;
    end else if (latch_req) begin
      req <= db_lvl;
    end
  end

  always_comb begin
    dx = 12'sd0;
    dy = 12'sd0;
    if (!req[0]) dx = dx + STEP_S;
    if (!req[1]) dx = dx - STEP_S;
    if (!req[2]) dy = dy + STEP_S;
    if (!req[3]) dy = dy - STEP_S;
    x_sum = $signed({2'b00, oBOX_X}) + dx;
    y_sum = $signed({2'b00, oBOX_Y}) + dy;
`ifdef BOX_MOTION_WRAP_EN
    if (x_sum > X_MAX)       x_new = 10'd0;
    else if (x_sum < 12'sd0) x_new = X_MAX10;
    else                     x_new = x_sum[9:0];
    if (y_sum > Y_MAX)       y_new = 10'd0;
    else if (y_sum < 12'sd0) y_new = Y_MAX10;
    else                     y_new = y_sum[9:0];
`else
    if (x_sum > X_MAX)       x_new = X_MAX10;
    else if (x_sum < 12'sd0) x_new = 10'd0;
    else                     x_new = x_sum[9:0];
    if (y_sum > Y_MAX)       y_new = Y_MAX10;
    else if (y_sum < 12'sd0) y_new = 10'd0;
    else                     y_new = y_sum[9:0];
`endif
  end

  // Position only moves on the APPLY exit edge, which always lies inside vertical sync.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      oBOX_X  <= 10'(X_INIT);
      oBOX_Y  <= 10'(Y_INIT);
      oMOVING <= 1'b0;
    end else begin
      oMOVING <= 1'b0;
      if (do_apply) begin
        oBOX_X  <= x_new;
        oBOX_Y  <= y_new;
        oMOVING <= (x_new != oBOX_X) || (y_new != oBOX_Y);
      end
    end
  end

endmodule

// File: tb/tb_box_motion_ctrl.sv
// Randomized bench for box_motion_ctrl against a transaction-level model of tick/request/vsync behaviour.
module tb_box_motion_ctrl;

  localparam int TICK_DIV  = 16;
  localparam int DB_CYCLES = 4;
  localparam int STEP      = 5;
  localparam int X_MAX     = 640 - 160;
  localparam int Y_MAX     = 480 - 160;
  localparam int X0        = 120;
  localparam int Y0        = 120;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       in1   = 1'b1;
  logic       in2   = 1'b1;
  logic       in3   = 1'b1;
  logic       in4   = 1'b1;
  logic       vs    = 1'b1;
  logic [9:0] box_x;
  logic [9:0] box_y;
  logic       moving;

  box_motion_ctrl #(
    .TICK_DIV (TICK_DIV),
    .STEP     (STEP),
    .DB_CYCLES(DB_CYCLES)
  ) dut (
    .iVGA_CLK(clk),
    .iRST_n  (rst_n),
    .in1     (in1),
    .in2     (in2),
    .in3     (in3),
    .in4     (in4),
    .iVS     (vs),
    .oBOX_X  (box_x),
    .oBOX_Y  (box_y),
    .oMOVING (moving)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: edges since reset, one optional pending request, scheduled apply.
  int         m_x;
  int         m_y;
  int         m_edges;
  bit         m_moving;
  bit         m_vs_prev;
  bit         m_pending;
  bit         m_apply;
  logic [3:0] m_req;
  logic [3:0] m_stable;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int delta(input bit pos_pressed, input bit neg_pressed);
    return (pos_pressed ? STEP : 0) - (neg_pressed ? STEP : 0);
  endfunction

  function automatic int next_coord(input int c, input int d, input int maxv);
    int n;
    n = c + d;
`ifdef BOX_MOTION_WRAP_EN
    if (n > maxv) n = 0;
    else if (n < 0) n = maxv;
`else
    if (n > maxv) n = maxv;
    else if (n < 0) n = 0;
`endif
    return n;
  endfunction

  task automatic model_reset();
    m_x       = X0;
    m_y       = Y0;
    m_edges   = 0;
    m_moving  = 1'b0;
    m_vs_prev = 1'b1;
    m_pending = 1'b0;
    m_apply   = 1'b0;
    m_req     = 4'hF;
    m_stable  = 4'hF;
  endtask

  task automatic model_edge(input logic v);
    bit tick;
    bit fall;
    int nx;
    int ny;
    m_edges++;
    tick      = (m_edges % TICK_DIV) == 0;
    fall      = m_vs_prev && !v;
    m_vs_prev = v;
    m_moving  = 1'b0;
    if (m_apply) begin
      nx = next_coord(m_x, delta(!m_req[0], !m_req[1]), X_MAX);
      ny = next_coord(m_y, delta(!m_req[2], !m_req[3]), Y_MAX);
      m_moving = (nx != m_x) || (ny != m_y);
      m_x = nx;
      m_y = ny;
      m_apply = 1'b0;
    end else if (m_pending) begin
      if (fall) begin
        m_apply   = 1'b1;
        m_pending = 1'b0;
      end
    end else if (tick && (m_stable != 4'hF)) begin
      m_pending = 1'b1;
      m_req     = m_stable;
    end
  endtask

  task automatic cycle(input logic [3:0] b, input logic v);
    {in4, in3, in2, in1} = b;
    vs = v;
    @(posedge clk);
    model_edge(v);
    @(negedge clk);
    check("box_x", box_x, m_x);
    check("box_y", box_y, m_y);
    check("moving", moving, m_moving);
  endtask

  // One tick period; buttons settle well before its closing tick, a glitch pulses only 2 cycles.
  task automatic period(input logic [3:0] b, input bit glitch, input int vs_off);
    m_stable = glitch ? 4'hF : b;
    for (int i = 0; i < TICK_DIV; i++) begin
      logic [3:0] bi;
      logic       vi;
      bi = (glitch && i >= 2) ? 4'hF : b;
      vi = !((vs_off >= 0) && (i == vs_off || i == vs_off + 1));
      cycle(bi, vi);
    end
  endtask

  task automatic do_reset();
    {in4, in3, in2, in1} = 4'hF;
    vs    = 1'b1;
    rst_n = 1'b0;
    #1;
    check("rst_x", box_x, X0);
    check("rst_y", box_y, Y0);
    check("rst_moving", moving, 0);
    repeat (3) @(negedge clk);
    check("rst_hold_x", box_x, X0);
    check("rst_hold_y", box_y, Y0);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [3:0] b;
    bit         g;
    int         o;
    model_reset();
    @(negedge clk);
    do_reset();

    for (int p = 0; p < 7; p++) period(4'hF, 1'b0, 5);

    period(4'b1110, 1'b0, -1);
    period(4'hF, 1'b0, 3);

    period(4'b1110, 1'b1, 4);
    period(4'hF, 1'b0, 4);

    period(4'b1000, 1'b0, -1);
    period(4'hF, 1'b0, 6);

    period(4'b1110, 1'b0, -1);
    do_reset();
    period(4'hF, 1'b0, 2);
    period(4'hF, 1'b0, 7);

    for (int p = 0; p < 80; p++) period(4'b1110, 1'b0, int'($urandom_range(0, 12)));
    for (int p = 0; p < 30; p++) period(4'b0111, 1'b0, int'($urandom_range(0, 12)));
    for (int p = 0; p < 40; p++) period(4'b0101, 1'b0, int'($urandom_range(0, 12)));

    for (int p = 0; p < 200; p++) begin
      b = 4'($urandom_range(0, 15));
      g = ($urandom_range(0, 7) == 0);
      o = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 12));
      period(b, g, o);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
